// File: rtl/ram_share_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NumReq requesters.
// A ReadLatency-deep tag pipeline steers each response strobe back to its issuer.
module ram_share_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned ReadLatency = 1,
  localparam int unsigned BeWidth    = DataWidth / 8,
  localparam int unsigned IdxWidth   = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0]                req_i,
  output logic [NumReq-1:0]                gnt_o,
  input  logic [NumReq-1:0]                we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] addr_i,
  input  logic [NumReq-1:0][BeWidth-1:0]   be_i,
  input  logic [NumReq-1:0][DataWidth-1:0] wdata_i,
  output logic [NumReq-1:0]                rvalid_o,
  output logic [DataWidth-1:0]             rdata_o,
  output logic                             ram_req_o,
  output logic                             ram_we_o,
  output logic [AddrWidth-1:0]             ram_addr_o,
  output logic [BeWidth-1:0]               ram_be_o,
  output logic [DataWidth-1:0]             ram_wdata_o,
  input  logic [DataWidth-1:0]             ram_rdata_i
);

  // Reads and writes produce identical strobes, so only the owner is tracked.
  typedef struct packed {
    logic                valid;
    logic [IdxWidth-1:0] owner;
  } resp_t;

  logic [IdxWidth-1:0]     ptr_q, ptr_d;
  resp_t [ReadLatency-1:0] pipe_q, pipe_d;
  logic                    win_valid;
  logic [IdxWidth-1:0]     win_idx;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = (32'(ptr_q) + off) % NumReq;
      if (!win_valid && req_i[IdxWidth'(idx)]) begin
        win_valid = 1'b1;
        win_idx   = IdxWidth'(idx);
      end
    end
  end

  always_comb begin
    gnt_o       = '0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (win_valid) begin
      gnt_o[win_idx] = 1'b1;
      ram_we_o       = we_i[win_idx];
      ram_addr_o     = addr_i[win_idx];
      ram_be_o       = be_i[win_idx];
      ram_wdata_o    = wdata_i[win_idx];
    end
  end

  assign ram_req_o = |req_i;
  assign rdata_o   = ram_rdata_i;

  always_comb begin
    ptr_d = ptr_q;
    if (win_valid) begin
      ptr_d = (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + IdxWidth'(1);
    end
    pipe_d          = pipe_q;
    pipe_d[0].valid = win_valid;
    pipe_d[0].owner = win_idx;
    for (int unsigned s = 1; s < ReadLatency; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  always_comb begin
    rvalid_o = '0;
    rvalid_o[pipe_q[ReadLatency-1].owner] = pipe_q[ReadLatency-1].valid;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      pipe_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      pipe_q <= pipe_d;
    end
  end

endmodule

// File: tb/tb_ram_share_arbiter.sv
// Bench for ram_share_arbiter: three configurations share one stimulus stream,
// each with its own RAM model, round-robin model and response scoreboard.
module tb_ram_share_arbiter;

  localparam int NI        = 3;
  localparam int NR  [NI]  = '{2, 3, 2};
  localparam int LAT [NI]  = '{1, 3, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       req, we;
  logic [2:0][63:0] addr, wdata;
  logic [2:0][7:0]  be;

  logic [1:0]  gnt_a, rv_a, gnt_c, rv_c;
  logic [2:0]  gnt_b, rv_b;
  logic [63:0] rdata [NI];
  logic [63:0] ram_addr [NI];
  logic [63:0] ram_wdata [NI];
  logic [63:0] ram_rdata [NI];
  logic [7:0]  ram_be [NI];
  logic        ram_req [NI];
  logic        ram_we [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ram_share_arbiter #(.NumReq(2), .AddrWidth(64), .DataWidth(64), .ReadLatency(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1:0]), .gnt_o(gnt_a), .we_i(we[1:0]),
    .addr_i(addr[1:0]), .be_i(be[1:0]), .wdata_i(wdata[1:0]), .rvalid_o(rv_a),
    .rdata_o(rdata[0]), .ram_req_o(ram_req[0]), .ram_we_o(ram_we[0]),
    .ram_addr_o(ram_addr[0]), .ram_be_o(ram_be[0]), .ram_wdata_o(ram_wdata[0]),
    .ram_rdata_i(ram_rdata[0]));

  ram_share_arbiter #(.NumReq(3), .AddrWidth(64), .DataWidth(64), .ReadLatency(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_b), .we_i(we),
    .addr_i(addr), .be_i(be), .wdata_i(wdata), .rvalid_o(rv_b),
    .rdata_o(rdata[1]), .ram_req_o(ram_req[1]), .ram_we_o(ram_we[1]),
    .ram_addr_o(ram_addr[1]), .ram_be_o(ram_be[1]), .ram_wdata_o(ram_wdata[1]),
    .ram_rdata_i(ram_rdata[1]));

  ram_share_arbiter #(.NumReq(2), .AddrWidth(64), .DataWidth(64), .ReadLatency(2)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1:0]), .gnt_o(gnt_c), .we_i(we[1:0]),
    .addr_i(addr[1:0]), .be_i(be[1:0]), .wdata_i(wdata[1:0]), .rvalid_o(rv_c),
    .rdata_o(rdata[2]), .ram_req_o(ram_req[2]), .ram_we_o(ram_we[2]),
    .ram_addr_o(ram_addr[2]), .ram_be_o(ram_be[2]), .ram_wdata_o(ram_wdata[2]),
    .ram_rdata_i(ram_rdata[2]));

  // RAM models: 32 words, read data appears LAT cycles after the sampled request.
  logic [63:0] mem   [NI][32];
  logic [63:0] rpipe [NI][4];

  assign ram_rdata[0] = rpipe[0][0];
  assign ram_rdata[1] = rpipe[1][2];
  assign ram_rdata[2] = rpipe[2][1];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        for (int k = 0; k < 32; k++)
          mem[i][k] <= (k == 1) ? 64'h0123_4567_89AB_CDEF : 64'(k) * 64'h1111_0000_0000_1111;
        for (int s = 0; s < 4; s++) rpipe[i][s] <= 64'h0;
      end else begin
        for (int s = 3; s > 0; s--) rpipe[i][s] <= rpipe[i][s-1];
        rpipe[i][0] <= 64'h0;
        if (ram_req[i] && ram_we[i]) begin
          for (int b = 0; b < 8; b++)
            if (ram_be[i][b]) mem[i][ram_addr[i][7:3]][8*b +: 8] <= ram_wdata[i][8*b +: 8];
        end else if (ram_req[i]) begin
          rpipe[i][0] <= mem[i][ram_addr[i][7:3]];
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] gnt_of(input int i);
    case (i)
      0:       return {1'b0, gnt_a};
      1:       return gnt_b;
      default: return {1'b0, gnt_c};
    endcase
  endfunction

  function automatic logic [2:0] rv_of(input int i);
    case (i)
      0:       return {1'b0, rv_a};
      1:       return rv_b;
      default: return {1'b0, rv_c};
    endcase
  endfunction

  // Scoreboard entry: which instance, due cycle, owner, direction and expected read data.
  typedef struct {
    int          inst;
    int          due;
    int          owner;
    bit          rd;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   mptr [NI];

  always @(negedge clk) begin
    int          w, hit, idx;
    logic        any;
    logic [2:0]  eg, erv;
    exp_t        e;
    if (!rst_n) sb.delete();
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) mptr[i] = 0;
      w   = -1;
      any = 1'b0;
      for (int k = 0; k < NR[i]; k++) begin
        idx = (mptr[i] + k) % NR[i];
        any = any | req[k];
        if (w < 0 && req[idx]) w = idx;
      end
      eg = (w >= 0) ? (3'b001 << w) : 3'b000;
      check($sformatf("gnt%0d", i), 64'(gnt_of(i)), 64'(eg));
      check($sformatf("ram_req%0d", i), 64'(ram_req[i]), 64'(any));
      if (w >= 0) begin
        check($sformatf("ram_addr%0d", i), ram_addr[i], addr[w]);
        check($sformatf("ram_we%0d", i), 64'(ram_we[i]), 64'(we[w]));
        if (we[w]) begin
          check($sformatf("ram_be%0d", i), 64'(ram_be[i]), 64'(be[w]));
          check($sformatf("ram_wdata%0d", i), ram_wdata[i], wdata[w]);
        end
      end else begin
        check($sformatf("idle_addr%0d", i), ram_addr[i], 64'h0);
        check($sformatf("idle_we_be%0d", i), 64'({ram_we[i], ram_be[i]}), 64'h0);
        check($sformatf("idle_wdata%0d", i), ram_wdata[i], 64'h0);
      end

      hit = -1;
      foreach (sb[j]) if (hit < 0 && sb[j].inst == i && sb[j].due == cyc) hit = j;
      erv = (hit >= 0) ? (3'b001 << sb[hit].owner) : 3'b000;
      check($sformatf("rvalid%0d", i), 64'(rv_of(i)), 64'(erv));
      check($sformatf("rv_onehot%0d", i), 64'($onehot0(rv_of(i))), 64'h1);
      if (hit >= 0) begin
        if (sb[hit].rd) check($sformatf("rdata%0d", i), rdata[i], sb[hit].data);
        sb.delete(hit);
      end

      if (rst_n && w >= 0) begin
        e.inst  = i;
        e.due   = cyc + LAT[i];
        e.owner = w;
        e.rd    = !we[w];
        e.data  = mem[i][addr[w][7:3]];
        sb.push_back(e);
        mptr[i] = (w + 1) % NR[i];
      end
    end
  end

  task automatic drive(input logic [2:0] r, input int n);
    req = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    req   = 3'b011;
    we    = 3'b000;
    addr  = '{64'h18, 64'h10, 64'h8};
    be    = '{8'hFF, 8'hFF, 8'hFF};
    wdata = '0;

    // Reset with two requests held: no strobes, first grant after release to req 0.
    drive(3'b011, 3);
    rst_n = 1'b1;
    drive(3'b011, 1);
    drive(3'b000, 4);

    // Single read of the preloaded word at 0x8.
    addr[0] = 64'h8;
    drive(3'b001, 1);
    drive(3'b000, 4);

    // Write by req 1, then read back by req 0.
    we[1]    = 1'b1;
    addr[1]  = 64'h10;
    be[1]    = 8'hFF;
    wdata[1] = 64'hDEAD_BEEF_0000_0001;
    drive(3'b010, 1);
    we[1]    = 1'b0;
    addr[0]  = 64'h10;
    drive(3'b001, 1);
    drive(3'b000, 4);

    // Contention between two, then all three requesters.
    addr[0] = 64'h8;
    addr[1] = 64'h10;
    addr[2] = 64'h18;
    drive(3'b011, 4);
    drive(3'b000, 4);
    drive(3'b111, 6);
    drive(3'b000, 4);

    // Mixed random traffic with partial byte enables.
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 3; r++) begin
        we[r]    = 1'($urandom_range(0, 1));
        addr[r]  = 64'($urandom_range(0, 31)) << 3;
        be[r]    = 8'($urandom);
        wdata[r] = {32'($urandom), 32'($urandom)};
      end
      drive(3'($urandom_range(0, 7)), 1);
    end
    drive(3'b000, 4);

    // Reset pulse right after a grant drops the in-flight response.
    we = 3'b000;
    drive(3'b001, 1);
    rst_n = 1'b0;
    drive(3'b000, 1);
    rst_n = 1'b1;
    drive(3'b000, 2);
    drive(3'b011, 1);
    drive(3'b000, 5);

    check("sb_drain", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
